decade_counter_ctrl: RTL and testbench

- Sequencer for the 4-bit decade counter (ports Q, P, Load, Enable).
- Accepts a job of {preset, wraps}, loads the preset into the counter, then enables counting until the counter has wrapped 9->0 the requested number of times.
- Reports done/abort/error and counts progress.
- Sits between the system request logic and the decade counter instance. It drives the counter's P, Load and Enable and observes its Q.

---
 rtl/decade_counter_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_decade_counter_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decade_counter_ctrl.sv
// ---------------------------------------------------------------------------
// decade_counter_ctrl
//
// Sequencer for an external 4-bit decade counter (ports Q, P, Load, Enable).
// It takes a job {preset, wraps}, loads the preset into the counter, then
// enables counting until the counter has wrapped MAX_DIGIT->0 the requested
// number of times. It reports done / aborted / err and counts the wraps.
//
// Optional build feature: define DECADE_CTRL_QCHECK_EN to add a shadow digit
// that predicts Q during RUN. A disagreement cancels the job with an err
// pulse. With the macro undefined, Q is only used for wrap detection.
//
// Ports
//   CLK       in   clock, rising edge
//   MR        in   synchronous active-high reset, overrides everything
//   start     in   job request, only looked at in IDLE
//   preset    in   [3:0]        job start digit, latched on accepted start
//   wraps     in   [WRAP_W-1:0] number of wraps to run, latched on accept
//   hold      in   pauses counting while in RUN
//   abort     in   cancels the job in LOAD or RUN
//   Q         in   [3:0]        counter output
//   P         out  [3:0]        preset value driven to the counter
//   Load      out  counter load strobe (high for the whole LOAD cycle)
//   Enable    out  counter count enable (RUN and not hold)
//   busy      out  job in progress (LOAD or RUN)
//   done      out  one-cycle pulse, job completed
//   aborted   out  one-cycle pulse, job cancelled by abort
//   err       out  one-cycle pulse, start rejected (or Q check failure)
//   wrap_cnt  out  [WRAP_W-1:0] wraps completed in the current/last job
//   state_dbg out  [1:0]        current FSM state (0 IDLE,1 LOAD,2 RUN,3 DONE)
//
// Handshake: start is a level sampled once per clock while IDLE. There is no
// queueing -- a start seen in any other state is dropped. done, aborted and
// err are single-cycle pulses and never overlap.
// ---------------------------------------------------------------------------
module decade_counter_ctrl #(
  parameter int unsigned WRAP_W    = 8,
  parameter logic [3:0]  MAX_DIGIT = 4'd9
) (
  input  logic              CLK,
  input  logic              MR,
  input  logic              start,
  input  logic [3:0]        preset,
  input  logic [WRAP_W-1:0] wraps,
  input  logic              hold,
  input  logic              abort,
  input  logic [3:0]        Q,
  output logic [3:0]        P,
  output logic              Load,
  output logic              Enable,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              err,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [WRAP_W-1:0] WRAP_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};
  localparam logic [WRAP_W-1:0] WRAP_MAX = {WRAP_W{1'b1}};

  state_t            state, state_n;
  logic [3:0]        p_q, p_n;
  logic [WRAP_W-1:0] remaining, remaining_n;
  logic [WRAP_W-1:0] wrap_q, wrap_n;
  logic              aborted_q, aborted_n;
  logic              err_q, err_n;
  logic              wrap_evt;
  logic              q_bad;

  // -------------------------------------------------------------------------
  // Outputs. Load/Enable/busy/done decode straight from the state so the
  // counter sees them in the same cycle; aborted/err are registered pulses.
  // -------------------------------------------------------------------------
  assign Load      = (state == ST_LOAD);
  assign Enable    = (state == ST_RUN) && !hold;
  assign busy      = (state == ST_LOAD) || (state == ST_RUN);
  assign done      = (state == ST_DONE);
  assign aborted   = aborted_q;
  assign err       = err_q;
  assign P         = p_q;
  assign wrap_cnt  = wrap_q;
  assign state_dbg = state;

  // Enable already implies RUN and no hold, so a held counter sitting on
  // MAX_DIGIT never counts as a wrap.
  assign wrap_evt = Enable && (Q == MAX_DIGIT);

`ifdef DECADE_CTRL_QCHECK_EN
  // -------------------------------------------------------------------------
  // Shadow digit: what Q should read in each RUN cycle if the counter obeyed
  // our Load/Enable. It is primed from P during LOAD and advanced mod
  // MAX_DIGIT+1 on every enabled RUN cycle.
  // -------------------------------------------------------------------------
  logic [3:0] shadow_q, shadow_n;
  logic       first_run_q, first_run_n;

  always_comb begin
    shadow_n    = shadow_q;
    first_run_n = 1'b0;
    q_bad       = 1'b0;
    if (state == ST_LOAD) begin
      shadow_n    = p_q;
      first_run_n = 1'b1;
    end else if (state == ST_RUN) begin
      // On the first RUN cycle the counter has just taken P; accept Q==P
      // there even if the shadow has not caught up.
      q_bad = (Q != shadow_q) && !(first_run_q && (Q == p_q));
      if (Enable) begin
        shadow_n = (shadow_q == MAX_DIGIT) ? 4'd0 : shadow_q + 4'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (MR) begin
      shadow_q    <= 4'd0;
      first_run_q <= 1'b0;
    end else begin
      shadow_q    <= shadow_n;
      first_run_q <= first_run_n;
    end
  end
`else
  assign q_bad = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Next-state and datapath update.
  // -------------------------------------------------------------------------
  always_comb begin
    state_n     = state;
    p_n         = p_q;
    remaining_n = remaining;
    wrap_n      = wrap_q;
    aborted_n   = 1'b0;
    err_n       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          if (preset > MAX_DIGIT) begin
            // Rejected job leaves P and wrap_cnt from the previous job.
            err_n = 1'b1;
          end else begin
            p_n         = preset;
            remaining_n = wraps;
            wrap_n      = '0;
            // A zero-wrap job completes without touching the counter.
            state_n     = (wraps == '0) ? ST_DONE : ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        if (abort) begin
          state_n   = ST_IDLE;
          aborted_n = 1'b1;
        end else begin
          state_n = ST_RUN;
        end
      end

      ST_RUN: begin
        // The wrap is recorded even when abort cancels the job on the same
        // edge; only a failed Q check discards it as untrustworthy.
        if (wrap_evt && !q_bad) begin
          if (wrap_q != WRAP_MAX) begin
            wrap_n = wrap_q + WRAP_ONE;
          end
          if (remaining != '0) begin
            remaining_n = remaining - WRAP_ONE;
          end
        end

        if (abort) begin
          state_n   = ST_IDLE;
          aborted_n = 1'b1;
        end else if (q_bad) begin
          state_n = ST_IDLE;
          err_n   = 1'b1;
        end else if (wrap_evt && (remaining <= WRAP_ONE)) begin
          state_n = ST_DONE;
        end
      end

      ST_DONE: begin
        state_n = ST_IDLE;
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (MR) begin
      state     <= ST_IDLE;
      p_q       <= 4'd0;
      remaining <= '0;
      wrap_q    <= '0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_n;
      p_q       <= p_n;
      remaining <= remaining_n;
      wrap_q    <= wrap_n;
      aborted_q <= aborted_n;
      err_q     <= err_n;
    end
  end

endmodule

// File: tb/tb_decade_counter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_decade_counter_ctrl
//
// Drives decade_counter_ctrl together with a small behavioural decade counter
// (load has priority over enable, 9 rolls to 0). Inputs change 1 time unit
// after the rising edge; outputs are sampled on the falling edge.
// Cycle k of a job is the k-th clock cycle after the edge that saw start.
// ---------------------------------------------------------------------------
module tb_decade_counter_ctrl;

  localparam int WRAP_W = 8;

  // clock / reset
  logic clk = 1'b0;
  logic mr;
  always #5 clk = ~clk;

  logic              start, hold, abort;
  logic [3:0]        preset;
  logic [WRAP_W-1:0] wraps;
  logic [3:0]        q;
  logic [3:0]        p;
  logic              load, enable, busy, done, aborted, err;
  logic [WRAP_W-1:0] wrap_cnt;
  logic [1:0]        state_dbg;

  decade_counter_ctrl #(.WRAP_W(WRAP_W), .MAX_DIGIT(4'd9)) dut (
    .CLK      (clk),
    .MR       (mr),
    .start    (start),
    .preset   (preset),
    .wraps    (wraps),
    .hold     (hold),
    .abort    (abort),
    .Q        (q),
    .P        (p),
    .Load     (load),
    .Enable   (enable),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted),
    .err      (err),
    .wrap_cnt (wrap_cnt),
    .state_dbg(state_dbg)
  );

  // external decade counter model; q_force lets a sequence corrupt Q
  logic [3:0] q_cnt;
  logic       q_force_en;
  logic [3:0] q_force;

  always @(posedge clk) begin
    if (mr)          q_cnt <= 4'd0;
    else if (load)   q_cnt <= p;
    else if (enable) q_cnt <= (q_cnt == 4'd9) ? 4'd0 : q_cnt + 4'd1;
  end
  assign q = q_force_en ? q_force : q_cnt;

  // scoreboard
  int checks   = 0;
  int failures = 0;
  logic [WRAP_W-1:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Issue one job and watch it for a fixed number of cycles.
  task automatic run_job(input logic [3:0] pr, input logic [WRAP_W-1:0] wr,
                         input int budget,
                         output int n_load, output int n_en, output int n_busy,
                         output int n_abt, output int n_multi,
                         output int done_at, output int err_at);
    logic [WRAP_W-1:0] prev;
    n_load = 0; n_en = 0; n_busy = 0; n_abt = 0; n_multi = 0;
    done_at = -1; err_at = -1;
    next_cycle();
    start = 1'b1; preset = pr; wraps = wr;
    prev = wrap_cnt;
    for (int k = 1; k <= budget; k++) begin
      next_cycle();
      start = 1'b0;
      sample();
      if (load)    n_load++;
      if (enable)  n_en++;
      if (busy)    n_busy++;
      if (aborted) n_abt++;
      if (int'(done) + int'(aborted) + int'(err) > 1) n_multi++;
      if (done && done_at < 0) done_at = k;
      if (err && err_at < 0)   err_at = k;
      if (wrap_cnt != prev) begin
        if (wrap_cnt != '0) begin
          if (exp_q.size() == 0) chk("wrap_seq_extra", int'(wrap_cnt), -1);
          else                   chk("wrap_seq", int'(wrap_cnt), int'(exp_q.pop_front()));
        end
        prev = wrap_cnt;
      end
    end
  endtask

  typedef struct {
    logic [3:0]        preset;
    logic [WRAP_W-1:0] wraps;
    int exp_load;
    int exp_en;
    int exp_done_at;
    int exp_err_at;
    int exp_wrap;
    int exp_p;
  } vec_t;

  vec_t vecs[7];

  function automatic int all_outs();
    return int'({p, load, enable, busy, done, aborted, err, wrap_cnt, state_dbg});
  endfunction

  initial begin
    int n_load, n_en, n_busy, n_abt, n_multi, done_at, err_at;
    int cnt_done, cnt_abt, cnt_err;

    //            preset wraps load en  done err wrap P
    vecs[0] = '{4'd7,  8'd2, 1,   13, 15,  -1, 2,   7};
    vecs[1] = '{4'd12, 8'd3, 0,   0,  -1,  1,  2,   7};
    vecs[2] = '{4'd4,  8'd0, 0,   0,  1,   -1, 0,   4};
    vecs[3] = '{4'd9,  8'd1, 1,   1,  3,   -1, 1,   9};
    vecs[4] = '{4'd0,  8'd1, 1,   10, 12,  -1, 1,   0};
    vecs[5] = '{4'd10, 8'd1, 0,   0,  -1,  1,  1,   0};
    vecs[6] = '{4'd3,  8'd3, 1,   27, 29,  -1, 3,   3};

    mr = 1'b1; start = 1'b0; hold = 1'b0; abort = 1'b0;
    preset = 4'd0; wraps = '0; q_force_en = 1'b0; q_force = 4'd0;

    // reset
    next_cycle(); next_cycle();
    sample();
    chk("reset_outs_during_mr", all_outs(), 0);
    next_cycle();
    mr = 1'b0;
    sample();
    chk("reset_outs_after_mr", all_outs(), 0);

    // table-driven jobs
    foreach (vecs[i]) begin
      if (vecs[i].exp_load == 1)
        for (int w = 1; w <= vecs[i].exp_wrap; w++) exp_q.push_back(WRAP_W'(w));
      run_job(vecs[i].preset, vecs[i].wraps, 32,
              n_load, n_en, n_busy, n_abt, n_multi, done_at, err_at);
      chk($sformatf("v%0d_load_cycles", i), n_load, vecs[i].exp_load);
      chk($sformatf("v%0d_enable_cycles", i), n_en, vecs[i].exp_en);
      chk($sformatf("v%0d_busy_cycles", i), n_busy, vecs[i].exp_load + vecs[i].exp_en);
      chk($sformatf("v%0d_done_at", i), done_at, vecs[i].exp_done_at);
      chk($sformatf("v%0d_err_at", i), err_at, vecs[i].exp_err_at);
      chk($sformatf("v%0d_aborted_cnt", i), n_abt, 0);
      chk($sformatf("v%0d_pulse_overlap", i), n_multi, 0);
      chk($sformatf("v%0d_wrap_cnt", i), int'(wrap_cnt), vecs[i].exp_wrap);
      chk($sformatf("v%0d_p", i), int'(p), vecs[i].exp_p);
      chk($sformatf("v%0d_wrap_q_left", i), exp_q.size(), 0);
      exp_q.delete();
    end

    // hold while Q=9: preset 8, wraps 1, hold in cycles 3..6
    next_cycle();
    start = 1'b1; preset = 4'd8; wraps = 8'd1;
    for (int k = 1; k <= 10; k++) begin
      next_cycle();
      start = 1'b0;
      hold = (k >= 3 && k <= 6);
      sample();
      if (k == 2) chk("hold_c2_enable", int'(enable), 1);
      if (k >= 3 && k <= 6) begin
        chk($sformatf("hold_c%0d_enable", k), int'(enable), 0);
        chk($sformatf("hold_c%0d_q", k), int'(q), 9);
        chk($sformatf("hold_c%0d_done", k), int'(done), 0);
      end
      if (k == 7) begin
        chk("hold_c7_enable", int'(enable), 1);
        chk("hold_c7_q", int'(q), 9);
      end
      if (k == 8) begin
        chk("hold_c8_done", int'(done), 1);
        chk("hold_c8_enable", int'(enable), 0);
        chk("hold_c8_wrap_cnt", int'(wrap_cnt), 1);
      end
    end
    hold = 1'b0;

    // abort after first wrap, with an ignored start while busy
    cnt_done = 0;
    next_cycle();
    start = 1'b1; preset = 4'd0; wraps = 8'd3;
    for (int k = 1; k <= 16; k++) begin
      next_cycle();
      start  = (k == 5);
      preset = (k == 5) ? 4'd2 : 4'd0;
      wraps  = (k == 5) ? 8'd1 : 8'd3;
      abort  = (k == 12);
      sample();
      if (done) cnt_done++;
      if (k == 12) begin
        chk("abort_c12_wrap_cnt", int'(wrap_cnt), 1);
        chk("abort_c12_busy", int'(busy), 1);
      end
      if (k == 13) begin
        chk("abort_c13_aborted", int'(aborted), 1);
        chk("abort_c13_busy", int'(busy), 0);
        chk("abort_c13_enable", int'(enable), 0);
        chk("abort_c13_state", int'(state_dbg), 0);
        chk("abort_c13_wrap_cnt", int'(wrap_cnt), 1);
      end
      if (k == 14) chk("abort_c14_aborted", int'(aborted), 0);
    end
    chk("abort_no_done", cnt_done, 0);
    chk("abort_busy_start_ignored_p", int'(p), 0);
    abort = 1'b0; wraps = '0;

    // abort coinciding with the final wrap: preset 9, wraps 1
    cnt_done = 0;
    next_cycle();
    start = 1'b1; preset = 4'd9; wraps = 8'd1;
    for (int k = 1; k <= 5; k++) begin
      next_cycle();
      start = 1'b0;
      abort = (k == 2);
      sample();
      if (done) cnt_done++;
      if (k == 3) begin
        chk("abtwrap_aborted", int'(aborted), 1);
        chk("abtwrap_wrap_cnt", int'(wrap_cnt), 1);
        chk("abtwrap_state", int'(state_dbg), 0);
      end
    end
    chk("abtwrap_no_done", cnt_done, 0);
    abort = 1'b0;

    // abort during LOAD: preset 5, wraps 1
    cnt_done = 0; n_en = 0;
    next_cycle();
    start = 1'b1; preset = 4'd5; wraps = 8'd1;
    for (int k = 1; k <= 6; k++) begin
      next_cycle();
      start = 1'b0;
      abort = (k == 1);
      sample();
      if (done)   cnt_done++;
      if (enable) n_en++;
      if (k == 1) chk("abtload_load", int'(load), 1);
      if (k == 2) begin
        chk("abtload_aborted", int'(aborted), 1);
        chk("abtload_state", int'(state_dbg), 0);
        chk("abtload_wrap_cnt", int'(wrap_cnt), 0);
      end
    end
    chk("abtload_no_done", cnt_done, 0);
    chk("abtload_no_enable", n_en, 0);
    abort = 1'b0;

    // MR for 2 cycles mid-RUN: preset 3, wraps 5
    cnt_done = 0; cnt_abt = 0;
    next_cycle();
    start = 1'b1; preset = 4'd3; wraps = 8'd5;
    for (int k = 1; k <= 14; k++) begin
      next_cycle();
      start = 1'b0;
      mr = (k == 7 || k == 8);
      sample();
      if (k >= 8 && done)    cnt_done++;
      if (k >= 8 && aborted) cnt_abt++;
      if (k == 6) chk("mr_c6_enable", int'(enable), 1);
      if (k == 8) chk("mr_c8_outs", all_outs(), 0);
      if (k == 9) chk("mr_c9_outs", all_outs(), 0);
    end
    chk("mr_no_done", cnt_done, 0);
    chk("mr_no_aborted", cnt_abt, 0);

    // corrupt Q in cycle 4 (counter should read 2): preset 0, wraps 1
    cnt_err = 0; cnt_abt = 0; done_at = -1;
    next_cycle();
    start = 1'b1; preset = 4'd0; wraps = 8'd1;
    for (int k = 1; k <= 14; k++) begin
      next_cycle();
      start = 1'b0;
      q_force_en = (k == 4);
      q_force = 4'd5;
      sample();
      if (err)     cnt_err++;
      if (aborted) cnt_abt++;
      if (done && done_at < 0) done_at = k;
      if (k == 4) chk("qchk_c4_q", int'(q), 5);
`ifdef DECADE_CTRL_QCHECK_EN
      if (k == 5) begin
        chk("qchk_c5_err", int'(err), 1);
        chk("qchk_c5_state", int'(state_dbg), 0);
        chk("qchk_c5_enable", int'(enable), 0);
        chk("qchk_c5_aborted", int'(aborted), 0);
      end
`endif
    end
    q_force_en = 1'b0;
`ifdef DECADE_CTRL_QCHECK_EN
    chk("qchk_err_count", cnt_err, 1);
    chk("qchk_no_done", done_at, -1);
`else
    chk("qchk_off_err_count", cnt_err, 0);
    chk("qchk_off_done_at", done_at, 12);
`endif
    chk("qchk_no_aborted", cnt_abt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
